// File: rtl/pio_reg_pkg.sv
// rtl/pio_reg_pkg.sv - shared constants, state type and byte-lane helper for the PIO register bank
package pio_reg_pkg;

    // Region codes on addr[13:12]
    localparam logic [1:0] REG_ZERO_LO = 2'b00;
    localparam logic [1:0] REG_BANK    = 2'b01;
    localparam logic [1:0] REG_ZERO_HI = 2'b10;
    localparam logic [1:0] REG_ROM     = 2'b11;

    // Per-channel dword offsets (addr[2:0])
    localparam logic [2:0] OFF_IFV4    = 3'd0;
    localparam logic [2:0] OFF_CTRL    = 3'd1;
    localparam logic [2:0] OFF_IFMACHI = 3'd2;
    localparam logic [2:0] OFF_IFMACLO = 3'd3;
    localparam logic [2:0] OFF_DV4     = 3'd4;
    localparam logic [2:0] OFF_RSVD    = 3'd5;
    localparam logic [2:0] OFF_DMACHI  = 3'd6;
    localparam logic [2:0] OFF_DMACLO  = 3'd7;

    // Global registers (addr[11:0])
    localparam logic [11:0] GA_ID     = 12'hF00;
    localparam logic [11:0] GA_COMMIT = 12'hF01;
    localparam logic [11:0] GA_ERR    = 12'hF02;
    localparam logic [11:0] GA_WRCNT  = 12'hF03;

    localparam logic [31:0] ID_BASE = 32'h504E_0000;

    // Reset addresses; channel k adds k to the local IPv4 and MAC
    localparam logic [31:0] DEF_IF_V4    = 32'h0A00_15C7;
    localparam logic [47:0] DEF_IF_MAC   = 48'h0037_7600_0001;
    localparam logic [31:0] DEF_DEST_V4  = 32'h0A00_15FF;
    localparam logic [47:0] DEF_DEST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } commit_state_t;

    // Lane 0 is the most significant byte
    function automatic logic [31:0] apply_be(input logic [31:0] cur,
                                             input logic [31:0] nxt,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = cur;
        if (be[0]) r[31:24] = nxt[31:24];
        if (be[1]) r[23:16] = nxt[23:16];
        if (be[2]) r[15:8]  = nxt[15:8];
        if (be[3]) r[7:0]   = nxt[7:0];
        return r;
    endfunction

endpackage

// File: rtl/pio_ep_reg_bank_if.sv
// rtl/pio_ep_reg_bank_if.sv - PIO read/write bus between the PCIe endpoint and the register bank
// Signals: rd_addr/rd_be/rd_data (1-cycle read), wr_addr/wr_be/wr_data/wr_en (strobe write),
// wr_busy (commit sequencer active). master = endpoint side, slave = register bank.
interface pio_ep_reg_bank_if;
    logic [13:0] rd_addr;
    logic [3:0]  rd_be;
    logic [31:0] rd_data;
    logic [13:0] wr_addr;
    logic [7:0]  wr_be;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        wr_busy;

    modport master (
        output rd_addr, rd_be, wr_addr, wr_be, wr_data, wr_en,
        input  rd_data, wr_busy
    );

    modport slave (
        input  rd_addr, rd_be, wr_addr, wr_be, wr_data, wr_en,
        output rd_data, wr_busy
    );
endinterface

// File: rtl/pio_reg_channel.sv
// rtl/pio_reg_channel.sv - one channel's shadow/live address registers and read mux
// Ports: clk, rst (async, active-high); wr_sel/wr_off/wr_be/wr_data host write into shadow;
// commit copies shadow to live; rd_off/debug8 -> rd_data (combinational shadow view);
// if_v4/if_mac/dest_v4/dest_mac/en are the live values.
module pio_reg_channel
    import pio_reg_pkg::*;
#(
    parameter int CH_IDX = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_sel,
    input  logic [2:0]  wr_off,
    input  logic [3:0]  wr_be,
    input  logic [31:0] wr_data,
    input  logic        commit,
    input  logic [2:0]  rd_off,
    input  logic [7:0]  debug8,
    output logic [31:0] rd_data,
    output logic [31:0] if_v4,
    output logic [47:0] if_mac,
    output logic [31:0] dest_v4,
    output logic [47:0] dest_mac,
    output logic        en
);

    localparam logic [31:0] RST_IF_V4  = DEF_IF_V4 + 32'(CH_IDX);
    localparam logic [47:0] RST_IF_MAC = DEF_IF_MAC + 48'(CH_IDX);

    logic [31:0] sh_if_v4;
    logic [47:0] sh_if_mac;
    logic [31:0] sh_dest_v4;
    logic [47:0] sh_dest_mac;
    logic        sh_en;
    logic        dirty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_if_v4    <= RST_IF_V4;
            sh_if_mac   <= RST_IF_MAC;
            sh_dest_v4  <= DEF_DEST_V4;
            sh_dest_mac <= DEF_DEST_MAC;
            sh_en       <= 1'b0;
        end else if (wr_sel) begin
            case (wr_off)
                OFF_IFV4:    sh_if_v4 <= apply_be(sh_if_v4, wr_data, wr_be);
                OFF_CTRL:    if (wr_be[3]) sh_en <= wr_data[0];
                OFF_IFMACHI: sh_if_mac[47:16] <= apply_be(sh_if_mac[47:16], wr_data, wr_be);
                OFF_IFMACLO: begin
                    // MAC low half lives in the top two lanes only
                    if (wr_be[0]) sh_if_mac[15:8] <= wr_data[31:24];
                    if (wr_be[1]) sh_if_mac[7:0]  <= wr_data[23:16];
                end
                OFF_DV4:     sh_dest_v4 <= apply_be(sh_dest_v4, wr_data, wr_be);
                OFF_DMACHI:  sh_dest_mac[47:16] <= apply_be(sh_dest_mac[47:16], wr_data, wr_be);
                OFF_DMACLO: begin
                    if (wr_be[0]) sh_dest_mac[15:8] <= wr_data[31:24];
                    if (wr_be[1]) sh_dest_mac[7:0]  <= wr_data[23:16];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_v4    <= RST_IF_V4;
            if_mac   <= RST_IF_MAC;
            dest_v4  <= DEF_DEST_V4;
            dest_mac <= DEF_DEST_MAC;
            en       <= 1'b0;
        end else if (commit) begin
            if_v4    <= sh_if_v4;
            if_mac   <= sh_if_mac;
            dest_v4  <= sh_dest_v4;
            dest_mac <= sh_dest_mac;
            en       <= sh_en;
        end
    end

    assign dirty = {sh_if_v4, sh_if_mac, sh_dest_v4, sh_dest_mac, sh_en}
                != {if_v4, if_mac, dest_v4, dest_mac, en};

    always_comb begin
        rd_data = '0;
        case (rd_off)
            OFF_IFV4:    rd_data = sh_if_v4;
            OFF_CTRL:    rd_data = {dirty, 30'b0, sh_en};
            OFF_IFMACHI: rd_data = sh_if_mac[47:16];
            OFF_IFMACLO: rd_data = {sh_if_mac[15:0], 8'h00, debug8};
            OFF_DV4:     rd_data = sh_dest_v4;
            OFF_RSVD:    rd_data = '0;
            OFF_DMACHI:  rd_data = sh_dest_mac[47:16];
            OFF_DMACLO:  rd_data = {sh_dest_mac[15:0], 16'h0};
            default:     rd_data = '0;
        endcase
    end

endmodule

// File: rtl/pio_ep_reg_bank.sv
// rtl/pio_ep_reg_bank.sv - multi-channel PIO register bank with atomic commit and ROM read mux
// Ports: clk, sys_rst (async, active-high); bus (pio_ep_reg_bank_if.slave) carries the PIO
// read/write bus and wr_busy; rom_data is the 1-cycle-latency ROM output; debug is shown in
// the MAC-lo reads; if_v4addr/if_macaddr/dest_v4addr/dest_macaddr/ch_en are the live values.
// Optional: PIO_REG_WRCNT_EN adds the 16-bit accepted-write counter at 0xF03.
module pio_ep_reg_bank
    import pio_reg_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int DEBUG_W = 8
) (
    input  logic                   clk,
    input  logic                   sys_rst,
    pio_ep_reg_bank_if.slave       bus,
    input  logic [31:0]            rom_data,
    input  logic [DEBUG_W-1:0]     debug,
    output logic [NUM_CH*32-1:0]   if_v4addr,
    output logic [NUM_CH*48-1:0]   if_macaddr,
    output logic [NUM_CH*32-1:0]   dest_v4addr,
    output logic [NUM_CH*48-1:0]   dest_macaddr,
    output logic [NUM_CH-1:0]      ch_en
);

    localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);

    // Write decode
    logic [1:0]        wr_region;
    logic              wr_glob;
    logic [CH_W-1:0]   wr_ch;
    logic [3:0]        be4;
    logic              wr_drop;
    logic              wr_ok;
    logic              bank_wr;
    logic [NUM_CH-1:0] mask_data;
    logic              commit_go;
    logic              err_clr;
    logic              err;

    assign wr_region = bus.wr_addr[13:12];
    assign wr_glob   = bus.wr_addr[11:8] == 4'hF;
    assign wr_ch     = bus.wr_addr[CH_W+2:3];
    assign be4       = bus.wr_be[3:0];

    // Only the error register stays writable during a commit, so the host can clear it
    assign wr_drop   = bus.wr_en && bus.wr_busy && (bus.wr_addr != {REG_BANK, GA_ERR});
    assign wr_ok     = bus.wr_en && !wr_drop;
    assign bank_wr   = wr_ok && (wr_region == REG_BANK);
    assign mask_data = NUM_CH'(apply_be(32'h0, bus.wr_data, be4));
    assign commit_go = bank_wr && (bus.wr_addr[11:0] == GA_COMMIT) && (mask_data != '0);
    assign err_clr   = bank_wr && (bus.wr_addr[11:0] == GA_ERR) && be4[3] && bus.wr_data[0];

    // Commit sequencer
    commit_state_t     state;
    commit_state_t     state_nxt;
    logic [CH_W-1:0]   idx;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] commit_vec;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (commit_go) state_nxt = ST_SCAN;
            ST_SCAN: if (idx == LAST_IDX) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.wr_busy = (state == ST_SCAN);
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            idx  <= '0;
            mask <= '0;
        end else if (state == ST_IDLE) begin
            if (commit_go) begin
                mask <= mask_data;
                idx  <= '0;
            end
        end else begin
            idx <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst)      err <= 1'b0;
        else if (wr_drop) err <= 1'b1;
        else if (err_clr) err <= 1'b0;
    end

`ifdef PIO_REG_WRCNT_EN
    logic [15:0] wrcnt;
    logic        wrcnt_clr;

    assign wrcnt_clr = bank_wr && (bus.wr_addr[11:0] == GA_WRCNT);

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst)        wrcnt <= '0;
        else if (wrcnt_clr) wrcnt <= '0;
        else if (bank_wr)   wrcnt <= wrcnt + 16'd1;
    end
`endif

    // Channels
    logic [7:0]  debug8;
    logic [31:0] ch_rd [NUM_CH];
    logic [2:0]  rd_off;

    assign debug8 = 8'(debug);
    assign rd_off = bus.rd_addr[2:0];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign commit_vec[k] = (state == ST_SCAN) && (idx == CH_W'(k)) && mask[k];

        pio_reg_channel #(.CH_IDX(k)) u_ch (
            .clk      (clk),
            .rst      (sys_rst),
            .wr_sel   (bank_wr && !wr_glob && (wr_ch == CH_W'(k))),
            .wr_off   (bus.wr_addr[2:0]),
            .wr_be    (be4),
            .wr_data  (bus.wr_data),
            .commit   (commit_vec[k]),
            .rd_off   (rd_off),
            .debug8   (debug8),
            .rd_data  (ch_rd[k]),
            .if_v4    (if_v4addr[32*k +: 32]),
            .if_mac   (if_macaddr[48*k +: 48]),
            .dest_v4  (dest_v4addr[32*k +: 32]),
            .dest_mac (dest_macaddr[48*k +: 48]),
            .en       (ch_en[k])
        );
    end

    // Read path: bank data and region are registered together, the ROM supplies its own
    // registered word in the same cycle, and the final select is a plain mux.
    logic            rd_glob;
    logic [CH_W-1:0] rd_ch;
    logic [31:0]     bank_rd;
    logic [31:0]     bank_q;
    logic [1:0]      region_q;

    assign rd_glob = bus.rd_addr[11:8] == 4'hF;
    assign rd_ch   = bus.rd_addr[CH_W+2:3];

    always_comb begin
        bank_rd = '0;
        if (rd_glob) begin
            case (bus.rd_addr[11:0])
                GA_ID:     bank_rd = ID_BASE | 32'(NUM_CH);
                GA_COMMIT: bank_rd = '0;
                GA_ERR:    bank_rd = {31'b0, err};
`ifdef PIO_REG_WRCNT_EN
                GA_WRCNT:  bank_rd = {16'h0, wrcnt};
`else
                GA_WRCNT:  bank_rd = '0;
`endif
                default:   bank_rd = '0;
            endcase
        end else if ({1'b0, rd_ch} < (CH_W+1)'(NUM_CH)) begin
            bank_rd = ch_rd[rd_ch];
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            bank_q   <= '0;
            region_q <= REG_ZERO_LO;
        end else begin
            bank_q   <= bank_rd;
            region_q <= bus.rd_addr[13:12];
        end
    end

    always_comb begin
        bus.rd_data = '0;
        case (region_q)
            REG_BANK:    bus.rd_data = bank_q;
            REG_ROM:     bus.rd_data = rom_data;
            REG_ZERO_LO: bus.rd_data = '0;
            REG_ZERO_HI: bus.rd_data = '0;
            default:     bus.rd_data = '0;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{bus.rd_be, bus.wr_be[7:4], debug};

endmodule

// File: tb/tb_pio_ep_reg_bank.sv
// tb/tb_pio_ep_reg_bank.sv - directed scoreboard bench for pio_ep_reg_bank
module tb_pio_ep_reg_bank;

    localparam int NUM_CH = 4;

    logic                  clk = 1'b0;
    logic                  sys_rst;
    logic [31:0]           rom_data;
    logic [7:0]            debug;
    logic [NUM_CH*32-1:0]  if_v4addr;
    logic [NUM_CH*48-1:0]  if_macaddr;
    logic [NUM_CH*32-1:0]  dest_v4addr;
    logic [NUM_CH*48-1:0]  dest_macaddr;
    logic [NUM_CH-1:0]     ch_en;

    pio_ep_reg_bank_if bus ();

    pio_ep_reg_bank #(.NUM_CH(NUM_CH), .CH_W(2), .DEBUG_W(8)) dut (
        .clk          (clk),
        .sys_rst      (sys_rst),
        .bus          (bus.slave),
        .rom_data     (rom_data),
        .debug        (debug),
        .if_v4addr    (if_v4addr),
        .if_macaddr   (if_macaddr),
        .dest_v4addr  (dest_v4addr),
        .dest_macaddr (dest_macaddr),
        .ch_en        (ch_en)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [7:0] be);
        @(negedge clk);
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.wr_be   = be;
        bus.wr_en   = 1'b1;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [13:0] a, input logic [31:0] e, input string tag);
        @(negedge clk);
        bus.rd_addr = a;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        check(tag_q.pop_front(), {32'h0, bus.rd_data}, {32'h0, exp_q.pop_front()});
    endtask

    task automatic busy_cycles(output int cnt);
        cnt = 0;
        while (bus.wr_busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic check_live_defaults(input string pfx);
        for (int k = 0; k < NUM_CH; k++) begin
            check($sformatf("%s_if_v4_%0d", pfx, k), {32'h0, if_v4addr[32*k +: 32]},
                  {32'h0, 32'h0A00_15C7 + 32'(k)});
            check($sformatf("%s_if_mac_%0d", pfx, k), {16'h0, if_macaddr[48*k +: 48]},
                  {16'h0, 48'h0037_7600_0001 + 48'(k)});
            check($sformatf("%s_dest_v4_%0d", pfx, k), {32'h0, dest_v4addr[32*k +: 32]},
                  {32'h0, 32'h0A00_15FF});
            check($sformatf("%s_dest_mac_%0d", pfx, k), {16'h0, dest_macaddr[48*k +: 48]},
                  {16'h0, 48'hFFFF_FFFF_FFFF});
        end
        check({pfx, "_ch_en"}, {60'h0, ch_en}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        sys_rst     = 1'b1;
        rom_data    = 32'h0;
        debug       = 8'h5A;
        bus.rd_addr = '0;
        bus.rd_be   = 4'hF;
        bus.wr_addr = '0;
        bus.wr_be   = '0;
        bus.wr_data = '0;
        bus.wr_en   = 1'b0;

        // Reset state
        #1;
        check("rst_busy", {63'h0, bus.wr_busy}, 64'h0);
        check("rst_rd_data", {32'h0, bus.rd_data}, 64'h0);
        repeat (2) @(negedge clk);
        sys_rst = 1'b0;
        check_live_defaults("rst");

        rd(14'h1000, 32'h0A00_15C7, "rd_ch0_ifv4");
        rd(14'h1008, 32'h0A00_15C8, "rd_ch1_ifv4");
        rd(14'h1001, 32'h0000_0000, "rd_ch0_ctrl");
        rd(14'h1002, 32'h0037_7600, "rd_ch0_machi");
        rd(14'h1003, 32'h0001_005A, "rd_ch0_maclo");
        rd(14'h1005, 32'h0000_0000, "rd_ch0_rsvd");
        rd(14'h1007, 32'hFFFF_0000, "rd_ch0_dmaclo");
        rd(14'h1F00, 32'h504E_0004, "rd_id");

        // Shadow write, live untouched
        wr(14'h1004, 32'hC0A8_0101, 8'h0F);
        rd(14'h1004, 32'hC0A8_0101, "rd_ch0_dv4_shadow");
        check("dest_v4_pre_commit", {32'h0, dest_v4addr[31:0]}, {32'h0, 32'h0A00_15FF});
        rd(14'h1001, 32'h8000_0000, "rd_ch0_dirty");

        // Byte lanes: be[0] -> [31:24], be[2] -> [15:8]; MAC-lo only takes lanes 0/1
        wr(14'h1000, 32'h1122_3344, 8'h05);
        rd(14'h1000, 32'h1100_33C7, "rd_ch0_ifv4_lanes");
        wr(14'h1003, 32'hABCD_1234, 8'h0F);
        rd(14'h1003, 32'hABCD_005A, "rd_ch0_maclo_wr");

        // Commit channel 0
        wr(14'h1F01, 32'h0000_0001, 8'h0F);
        busy_cycles(cnt);
        check("commit_busy_cycles", 64'(cnt), 64'(NUM_CH));
        check("commit_dest_v4", {32'h0, dest_v4addr[31:0]}, {32'h0, 32'hC0A8_0101});
        check("commit_if_v4", {32'h0, if_v4addr[31:0]}, {32'h0, 32'h1100_33C7});
        check("commit_if_mac", {16'h0, if_macaddr[47:0]}, {16'h0, 48'h0037_7600_ABCD});
        check("commit_ch1_untouched", {32'h0, if_v4addr[63:32]}, {32'h0, 32'h0A00_15C8});
        rd(14'h1001, 32'h0000_0000, "rd_ch0_clean");
        rd(14'h1F01, 32'h0000_0000, "rd_commit_reg");

        // Zero mask is a no-op
        wr(14'h1F01, 32'h0000_0000, 8'h0F);
        check("zero_mask_idle", {63'h0, bus.wr_busy}, 64'h0);

        // Enable channel 1 and commit it
        wr(14'h1009, 32'h0000_0001, 8'h0F);
        rd(14'h1009, 32'h8000_0001, "rd_ch1_ctrl_dirty");
        wr(14'h1F01, 32'h0000_0002, 8'h0F);
        busy_cycles(cnt);
        check("ch1_busy_cycles", 64'(cnt), 64'(NUM_CH));
        check("ch1_en_live", {60'h0, ch_en}, 64'h2);

        // Write during commit is dropped and flagged
        wr(14'h1F01, 32'h0000_0001, 8'h0F);
        wr(14'h1000, 32'hDEAD_0000, 8'h0F);
        busy_cycles(cnt);
        check("drop_busy_done", 64'(cnt < 100), 64'h1);
        rd(14'h1000, 32'h1100_33C7, "rd_drop_unchanged");
        rd(14'h1F02, 32'h0000_0001, "rd_err_set");
        wr(14'h1F02, 32'h0000_0001, 8'h0F);
        rd(14'h1F02, 32'h0000_0000, "rd_err_clr");

        // ROM and zero regions
        rom_data = 32'hDEAD_BEEF;
        rd(14'h3005, 32'hDEAD_BEEF, "rd_rom");
        rd(14'h0005, 32'h0000_0000, "rd_region0");
        rd(14'h2005, 32'h0000_0000, "rd_region2");
        wr(14'h0000, 32'h5555_5555, 8'h0F);
        rd(14'h1000, 32'h1100_33C7, "rd_region0_wr_ignored");

`ifdef PIO_REG_WRCNT_EN
        wr(14'h1F03, 32'h0, 8'h0F);
        rd(14'h1F03, 32'h0000_0000, "rd_wrcnt_clr");
        for (int i = 0; i < 5; i++) wr(14'h1018, 32'(i), 8'h0F);
        rd(14'h1F03, 32'h0000_0005, "rd_wrcnt_5");
`else
        rd(14'h1F03, 32'h0000_0000, "rd_wrcnt_off");
`endif

        // Reset in the middle of a scan
        wr(14'h1008, 32'h0102_0304, 8'h0F);
        wr(14'h1F01, 32'h0000_000F, 8'h0F);
        @(negedge clk);
        check("busy_before_rst", {63'h0, bus.wr_busy}, 64'h1);
        #1 sys_rst = 1'b1;
        #1;
        check("rst_async_busy", {63'h0, bus.wr_busy}, 64'h0);
        check_live_defaults("midrst");
        @(negedge clk);
        sys_rst = 1'b0;
        rd(14'h1008, 32'h0A00_15C8, "rd_ch1_shadow_rst");
        rd(14'h1009, 32'h0000_0000, "rd_ch1_ctrl_rst");
        rd(14'h1F02, 32'h0000_0000, "rd_err_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
